// File: rtl/tanh_grad_if.sv
// ============================================================================
//  tanh_grad_if : operand/result handshake bundle for tanh_grad
//  Rev 1.0
// ============================================================================
`default_nettype none

interface tanh_grad_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] i_y;
  logic [WIDTH-1:0] i_err;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] o_delta;
  logic             o_valid;
  logic             i_ready;

  modport slave (
    input  i_y, i_err, i_valid, i_ready,
    output o_ready, o_delta, o_valid
  );

  modport master (
    output i_y, i_err, i_valid, i_ready,
    input  o_ready, o_delta, o_valid
  );
endinterface

`default_nettype wire

// File: rtl/tanh_grad.sv
// ============================================================================
//  tanh_grad : delta = err * (1 - y^2) in Q8.24 using one shift-add multiplier
//  Rev 1.0
// ============================================================================
`default_nettype none

module tanh_grad #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  tanh_grad_if.slave  bus
);

  localparam logic [31:0] c_ONE = 32'h0100_0000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SQ   = 3'd1,
    S_SUB  = 3'd2,
    S_MUL  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  // Only product bits [55:0] are ever observed, so the datapath is 56 bits wide.
  logic [55:0] r_acc;
  logic [55:0] r_mcand;
  logic [31:0] r_mplier;
  logic [4:0]  r_cnt;
  logic [31:0] r_err_abs;
  logic        r_sign;
  logic [31:0] r_delta;

  logic [31:0] w_y_abs;
  logic [31:0] w_y_clamp;
  logic [31:0] w_err_abs;
  logic [55:0] w_acc_next;
  logic [31:0] w_mag;
  logic [31:0] w_d;
  logic        w_last;

  assign w_y_abs    = bus.i_y[31] ? (32'd0 - bus.i_y) : bus.i_y;
  assign w_y_clamp  = (w_y_abs > c_ONE) ? c_ONE : w_y_abs;
  assign w_err_abs  = bus.i_err[31] ? (32'd0 - bus.i_err) : bus.i_err;
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : 56'd0);
  assign w_mag      = w_acc_next[55:24];
  assign w_d        = c_ONE - r_acc[55:24];
  assign w_last     = (r_cnt == 5'd31);

  assign bus.o_ready = (r_state == S_IDLE) && rst_n;
  assign bus.o_valid = (r_state == S_DONE);
  assign bus.o_delta = r_delta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.i_valid) w_state_next = S_SQ;
      S_SQ:    if (w_last)      w_state_next = S_SUB;
      S_SUB:                    w_state_next = S_MUL;
      S_MUL:   if (w_last)      w_state_next = S_DONE;
      S_DONE:  if (bus.i_ready) w_state_next = S_IDLE;
      default:                  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_err_abs <= '0;
      r_sign    <= 1'b0;
      r_delta   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_valid) begin
            r_mcand   <= {24'd0, w_y_clamp};
            r_mplier  <= w_y_clamp;
            r_err_abs <= w_err_abs;
            r_sign    <= bus.i_err[31];
            r_acc     <= '0;
            r_cnt     <= '0;
          end
        end
        S_SQ, S_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 5'd1;
          if (r_state == S_MUL && w_last)
            r_delta <= r_sign ? (32'd0 - w_mag) : w_mag;
        end
        S_SUB: begin
          r_mcand  <= {24'd0, r_err_abs};
          r_mplier <= w_d;
          r_acc    <= '0;
          r_cnt    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tanh_grad.sv
// ============================================================================
//  tb_tanh_grad : scoreboard bench for tanh_grad
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_tanh_grad;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic [31:0] q_exp[$];

  tanh_grad_if #(.WIDTH(32)) bus ();

  tanh_grad #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] y, input logic [31:0] e);
    logic [31:0] ya, ea, d, mag;
    logic [63:0] p;
    ya = y[31] ? -y : y;
    if (ya > 32'h0100_0000) ya = 32'h0100_0000;
    p   = {32'd0, ya} * {32'd0, ya};
    d   = 32'h0100_0000 - p[55:24];
    ea  = e[31] ? -e : e;
    p   = {32'd0, ea} * {32'd0, d};
    mag = p[55:24];
    return e[31] ? -mag : mag;
  endfunction

  task automatic accept(input logic [31:0] y, input logic [31:0] e, output int e0);
    int k;
    k = 0;
    while (!bus.o_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("ready_idle", bus.o_ready, 1);
    bus.i_y     = y;
    bus.i_err   = e;
    bus.i_valid = 1'b1;
    bus.i_ready = 1'b0;
    q_exp.push_back(model(y, e));
    @(negedge clk);
    e0 = cyc;
    chk("ready_busy", bus.o_ready, 0);
  endtask

  task automatic run_one(input logic [31:0] y, input logic [31:0] e, input int bp);
    int e0, k;
    logic [31:0] exp_d, held;
    accept(y, e, e0);
    k = 0;
    while (!bus.o_valid && k < 100) begin
      bus.i_valid = 1'($urandom_range(0, 1));
      bus.i_y     = $urandom;
      bus.i_err   = $urandom;
      @(negedge clk);
      k++;
    end
    bus.i_valid = 1'b0;
    chk("latency", 64'(cyc - e0), 65);
    exp_d = (q_exp.size() > 0) ? q_exp.pop_front() : 32'hDEAD_BEEF;
    chk("delta", bus.o_delta, exp_d);
    held = bus.o_delta;
    for (int i = 0; i < bp; i++) begin
      bus.i_valid = 1'b1;
      @(negedge clk);
      chk("bp_valid", bus.o_valid, 1);
      chk("bp_delta", bus.o_delta, held);
      chk("bp_ready", bus.o_ready, 0);
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_ready = 1'b0;
    chk("hs_valid", bus.o_valid, 0);
    chk("hs_ready", bus.o_ready, 1);
    chk("hs_delta", bus.o_delta, held);
  endtask

  initial begin
    int e0;
    bus.i_y = '0; bus.i_err = '0; bus.i_valid = 1'b0; bus.i_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.o_ready, 0);
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_delta", bus.o_delta, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", bus.o_ready, 1);

    run_one(32'h0000_0000, 32'h0100_0000, 0);
    run_one(32'h0080_0000, 32'h0100_0000, 0);
    run_one(32'hFF80_0000, 32'hFE00_0000, 10);

    // Abort mid-MUL with a non-zero result still in the output register.
    accept(32'h0040_0000, 32'h0100_0000, e0);
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", bus.o_valid, 0);
    chk("abort_delta", bus.o_delta, 0);
    chk("abort_ready", bus.o_ready, 0);
    void'(q_exp.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_rel_ready", bus.o_ready, 1);
    run_one(32'h0080_0000, 32'h0100_0000, 0);

    run_one(32'h0140_0000, 32'h0050_0000, 0);
    run_one(32'h0100_0000, 32'h0050_0000, 0);
    run_one(32'h8000_0000, 32'h8000_0000, 0);
    run_one(32'h0000_0000, 32'h8000_0000, 2);
    for (int i = 0; i < 4; i++)
      run_one({{7{1'b0}}, 25'($urandom)}, $urandom, i);
    run_one($urandom, $urandom, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
